// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder.
// No logic of its own; byte-merge helper is purely combinational.
// Not applicable: no flow control here.
package pkg_mem_if;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_WAIT = 2'd1,
        MR_RESP = 2'd2
    } mr_state_t;

    localparam int MEM_BE_W             = 4;
    localparam int MEM_WORD_OFFSET_BITS = 2;

    // Replace each byte lane of old_w whose enable bit is set with the
    // corresponding lane of wdata.
    function automatic logic [31:0] be_merge(
        input logic [31:0]         old_w,
        input logic [31:0]         wdata,
        input logic [MEM_BE_W-1:0] be
    );
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < MEM_BE_W; k++) begin
            if (be[k]) begin
                r[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with word array M[] and programmable latency.
// Latency: accept on edge N -> rsp_valid sampled high from edge N+LATENCY.
// Backpressure: req_ready low while a transaction is in flight; response held until rsp_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_addr/req_we/req_wdata/req_be : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                : response channel
module mem_responder
    import pkg_mem_if::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [MEM_BE_W-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (LATENCY < 1 || LATENCY > 15) begin : g_lat_check
        $error("mem_responder: LATENCY must be in 1..15");
    end

    // Word storage; deliberately has no reset so preloaded contents survive reset.
    logic [DATA_WIDTH-1:0] M [DEPTH_WORDS];

    mr_state_t             state, state_nxt;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MEM_BE_W-1:0]   be_q;

    logic                  accept;
    logic                  enter_resp;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_we;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [MEM_BE_W-1:0]   cur_be;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_err;

    // Ready is gated by reset so it reads 0 throughout reset even though
    // the state register sits in MR_IDLE.
    assign req_ready = (state == MR_IDLE) && reset;
    assign rsp_valid = (state == MR_RESP);
    assign accept    = req_valid && req_ready;

    // With LATENCY==1 the response edge is the accept edge, so the live
    // request fields are used there; otherwise the latched copy is used.
    assign cur_addr  = (state == MR_IDLE) ? req_addr  : addr_q;
    assign cur_we    = (state == MR_IDLE) ? req_we    : we_q;
    assign cur_wdata = (state == MR_IDLE) ? req_wdata : wdata_q;
    assign cur_be    = (state == MR_IDLE) ? req_be    : be_q;
    assign cur_idx   = cur_addr[MEM_WORD_OFFSET_BITS +: IDX_W];
    assign cur_err   = (cur_addr[MEM_WORD_OFFSET_BITS-1:0] != '0) ||
                       ({{MEM_WORD_OFFSET_BITS{1'b0}}, cur_addr[ADDR_WIDTH-1:MEM_WORD_OFFSET_BITS]}
                        >= ADDR_WIDTH'(DEPTH_WORDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        enter_resp = 1'b0;
        case (state)
            MR_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt  = MR_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = MR_WAIT;
                    end
                end
            end
            MR_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt  = MR_RESP;
                    enter_resp = 1'b1;
                end
            end
            MR_RESP: begin
                if (rsp_ready) begin
                    state_nxt = MR_IDLE;
                end
            end
            default: state_nxt = MR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == MR_WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_err || cur_we) ? '0 : M[cur_idx];
            end else if (rsp_valid && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    // Writes commit only on the edge entering MR_RESP; a reset before that
    // edge forces MR_IDLE and so drops the pending write.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err) begin
            M[cur_idx] <= be_merge(M[cur_idx], cur_wdata, cur_be);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 1 and 3) with scoreboard queues.
// Expected responses are queued at accept time; a negedge monitor pops on handshake.
// Monitor also checks that the response edge sits LATENCY edges after accept.
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk;
    logic        reset_n   [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_we    [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t exp_q [2][$];
    int   lat_of [2] = '{1, 3};
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic prev_v [2] = '{1'b0, 1'b0};

    mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_we(req_we[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_we(req_we[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: timing check on the first response cycle, data check on handshake.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        always @(negedge clk) begin
            if (rsp_valid[g] && !prev_v[g]) begin
                if (exp_q[g].size() == 0) begin
                    chk($sformatf("unexpected_rsp%0d", g), 32'd1, 32'd0);
                end else begin
                    chk($sformatf("latency%0d", g), 32'(cyc + 1 - exp_q[g][0].acc), 32'(lat_of[g]));
                end
            end
            if (rsp_valid[g] && rsp_ready[g] && exp_q[g].size() != 0) begin
                exp_t e;
                e = exp_q[g].pop_front();
                chk($sformatf("rdata%0d", g), rsp_rdata[g], e.rdata);
                chk($sformatf("err%0d", g), {31'd0, rsp_err[g]}, {31'd0, e.err});
            end
            prev_v[g] = rsp_valid[g];
        end
    end

    // Present a request at a negedge, wait (bounded) for acceptance, queue
    // the expected response and return just after the accepting edge.
    task automatic issue(input int g, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input bit keep, output int acc);
        int n;
        exp_t e;
        @(negedge clk);
        req_addr[g]  = addr;
        req_we[g]    = we;
        req_wdata[g] = wdata;
        req_be[g]    = be;
        req_valid[g] = 1'b1;
        n = 0;
        while (!req_ready[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (n >= 100) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req_valid[g] = 1'b0;
        end else begin
            acc     = cyc + 1;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.acc   = acc;
            exp_q[g].push_back(e);
            @(posedge clk);
            #1;
            if (!keep) req_valid[g] = 1'b0;
        end
    endtask

    task automatic drain(input int g);
        int n;
        n = 0;
        while (exp_q[g].size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        for (int g = 0; g < 2; g++) begin
            reset_n[g] = 1'b0; req_valid[g] = 1'b0; req_addr[g] = '0; req_we[g] = 1'b0;
            req_wdata[g] = '0; req_be[g] = '0; rsp_ready[g] = 1'b1;
        end
        u_dut_l1.M[0]    = 32'h0000_0013;
        u_dut_l1.M[1]    = 32'hCAFE_F00D;
        u_dut_l1.M[1023] = 32'hA5A5_0001;
        u_dut_l3.M[0]    = 32'h0000_0013;
        u_dut_l3.M[1]    = 32'h5555_0055;
        u_dut_l3.M[2]    = 32'h1122_3344;
        u_dut_l3.M[3]    = 32'h3333_3333;

        // Reset state
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_req_ready", {31'd0, req_ready[g]}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid[g]}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[g], 32'd0);
            chk("rst_rsp_err",   {31'd0, rsp_err[g]}, 32'd0);
        end
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        @(negedge clk);
        chk("rel_req_ready0", {31'd0, req_ready[0]}, 32'd1);
        chk("rel_req_ready1", {31'd0, req_ready[1]}, 32'd1);

        // 1: LATENCY=1 read of preloaded word
        issue(0, 32'd0, 1'b0, 32'd0, 4'h0, 32'h0000_0013, 1'b0, 1'b0, a0);
        drain(0);

        // 2: LATENCY=3 partial write then read back
        issue(1, 32'd8, 1'b1, 32'hDEAD_BEEF, 4'b0101, 32'd0, 1'b0, 1'b0, a0);
        issue(1, 32'd8, 1'b0, 32'd0, 4'h0, 32'h11AD_33EF, 1'b0, 1'b0, a0);
        drain(1);

        // 3: error cases leave memory untouched; be==0 write is a clean no-op
        issue(0, 32'd6,    1'b0, 32'd0,         4'h0, 32'd0, 1'b1, 1'b0, a0);
        issue(0, 32'd4096, 1'b0, 32'd0,         4'h0, 32'd0, 1'b1, 1'b0, a0);
        issue(0, 32'd5,    1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 1'b0, a0);
        issue(0, 32'd4096, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 1'b0, a0);
        issue(0, 32'd4,    1'b1, 32'h1234_5678, 4'h0, 32'd0, 1'b0, 1'b0, a0);
        issue(0, 32'd4,    1'b0, 32'd0,         4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, a0);
        issue(0, 32'd4092, 1'b0, 32'd0,         4'h0, 32'hA5A5_0001, 1'b0, 1'b0, a0);
        drain(0);

        // 4: response stall holds outputs and blocks new requests
        @(posedge clk); #1 rsp_ready[0] = 1'b0;
        issue(0, 32'd0, 1'b0, 32'd0, 4'h0, 32'h0000_0013, 1'b0, 1'b0, a0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            chk("stall_rsp_rdata", rsp_rdata[0], 32'h0000_0013);
            chk("stall_rsp_err",   {31'd0, rsp_err[0]}, 32'd0);
            chk("stall_req_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("unstall_req_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("unstall_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);

        // 5: reset during the wait of a write abandons it
        issue(1, 32'd12, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0, 1'b0, a0);
        @(negedge clk);
        reset_n[1] = 1'b0;
        #1;
        void'(exp_q[1].pop_back());
        chk("midrst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready[1]}, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata[1], 32'd0);
        chk("midrst_rsp_err",   {31'd0, rsp_err[1]}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n[1] = 1'b1;
        @(negedge clk);
        chk("postrst_req_ready", {31'd0, req_ready[1]}, 32'd1);
        issue(1, 32'd12, 1'b0, 32'd0, 4'h0, 32'h3333_3333, 1'b0, 1'b0, a0);
        drain(1);

        // 6: back-to-back with req_valid held high
        issue(1, 32'd0, 1'b0, 32'd0, 4'h0, 32'h0000_0013, 1'b0, 1'b1, a0);
        issue(1, 32'd4, 1'b0, 32'd0, 4'h0, 32'h5555_0055, 1'b0, 1'b1, a1);
        issue(1, 32'd8, 1'b0, 32'd0, 4'h0, 32'h11AD_33EF, 1'b0, 1'b0, a2);
        chk("b2b_l3_gap0", 32'(a1 - a0), 32'd4);
        chk("b2b_l3_gap1", 32'(a2 - a1), 32'd4);
        drain(1);
        issue(0, 32'd0, 1'b0, 32'd0, 4'h0, 32'h0000_0013, 1'b0, 1'b1, a0);
        issue(0, 32'd4, 1'b0, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, a1);
        chk("b2b_l1_gap", 32'(a1 - a0), 32'd2);
        drain(0);

        chk("leftover0", 32'(exp_q[0].size()), 32'd0);
        chk("leftover1", 32'(exp_q[1].size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
